// File: rtl/spoon_uart_tx_if.sv
// Non-backpressured bytestream: one-cycle write strobe qualifies data; there is no ready.
interface spoon_uart_tx_if;
  logic [7:0] data;
  logic       write;

  modport master (output data, output write);
  modport slave  (input  data, input  write);
endinterface

// File: rtl/spoon_uart_tx.sv
// 8N1 serial transmitter feeding the CD-i pointing device RX line, with a small
// drop-on-full FIFO, RTS-driven flush and a sticky overflow flag.
module spoon_uart_tx #(
  parameter int unsigned kTicksPerBit          = 25000,
  parameter int unsigned kTicksPerBitOverclock = 20000,
  parameter int unsigned kFifoDepth            = 4
) (
  input  logic           clk,
  input  logic           reset,
  spoon_uart_tx_if.slave serial_in,
  input  logic           overclock,
  input  logic           flush,
  output logic           txd,
  output logic           busy,
  output logic           overflow
);

  localparam int unsigned kPtrW    = (kFifoDepth > 1) ? $clog2(kFifoDepth) : 1;
  localparam int unsigned kCntW    = kPtrW + 1;
  localparam int unsigned kTickMax = (kTicksPerBit > kTicksPerBitOverclock) ?
                                     kTicksPerBit : kTicksPerBitOverclock;
  localparam int unsigned kTimerW  = $clog2(kTickMax + 1);

  localparam logic [kTimerW-1:0] kReloadStd = kTimerW'(kTicksPerBit - 1);
  localparam logic [kTimerW-1:0] kReloadOc  = kTimerW'(kTicksPerBitOverclock - 1);
  localparam logic [kCntW-1:0]   kFull      = kCntW'(kFifoDepth);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]         mem [kFifoDepth];
  logic [kPtrW-1:0]   wr_ptr;
  logic [kPtrW-1:0]   rd_ptr;
  logic [kCntW-1:0]   count;
  logic [kCntW-1:0]   count_n;

  logic [1:0]         state;
  logic [1:0]         state_n;
  logic [kTimerW-1:0] timer;
  logic [kTimerW-1:0] timer_n;
  logic [2:0]         bit_idx;
  logic [2:0]         bit_idx_n;
  logic [7:0]         shift;
  logic               frame_oc;
  logic               txd_n;

  logic               timer_done;
  logic               pop;
  logic               push;
  logic               drop;
  logic [kTimerW-1:0] pop_reload;
  logic [kTimerW-1:0] bit_reload;

  assign timer_done = (timer == '0);

  // Flush wins over everything: no pop, no push, and the discarded write is not an overflow.
  assign pop  = !flush && (count != '0) &&
                ((state == IDLE) || ((state == STOP) && timer_done));
  assign push = serial_in.write && !flush && ((count != kFull) || pop);
  assign drop = serial_in.write && !flush && (count == kFull) && !pop;

  // The rate is sampled at pop so a mid-frame overclock change only affects the next frame.
  assign pop_reload = overclock ? kReloadOc : kReloadStd;
  assign bit_reload = frame_oc  ? kReloadOc : kReloadStd;

  always_comb begin
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else if (push && !pop) begin
      count_n = count + kCntW'(1);
    end else if (pop && !push) begin
      count_n = count - kCntW'(1);
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    txd_n     = txd;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (pop) begin
          state_n = START;
          timer_n = pop_reload;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (timer_done) begin
          state_n   = DATA;
          bit_idx_n = '0;
          timer_n   = bit_reload;
          txd_n     = shift[0];
        end else begin
          timer_n = timer - kTimerW'(1);
        end
      end
      DATA: begin
        if (timer_done) begin
          timer_n = bit_reload;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            txd_n     = shift[bit_idx + 3'd1];
          end
        end else begin
          timer_n = timer - kTimerW'(1);
        end
      end
      STOP: begin
        if (timer_done) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (pop) begin
            state_n = START;
            timer_n = pop_reload;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          timer_n = timer - kTimerW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      shift    <= '0;
      frame_oc <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      txd     <= txd_n;
      count   <= count_n;
      busy    <= (state_n != IDLE) || (count_n != '0);
      if (drop) begin
        overflow <= 1'b1;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + kPtrW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + kPtrW'(1);
        end
      end
      if (pop) begin
        shift    <= mem[rd_ptr];
        frame_oc <= overclock;
      end
    end
  end

  // On a full FIFO with simultaneous pop, the write lands in the slot being read;
  // non-blocking semantics hand the old byte to the shift register first.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= serial_in.data;
    end
  end

endmodule

// File: doc/spoon_uart_tx.md
Name: spoon_uart_tx

Overview:
- Serial line transmitter directly downstream of the pointing device byte generator.
- Accepts bytes on a non-backpressured bytestream sink and buffers them in a small FIFO.
- Serializes the bytes as 8N1 frames at 1200 baud, or at the overclocked rate, onto the pointing device RX line of the CD-i slave controller.
- The upstream stage paces itself and never checks for space, so this block must absorb short bursts and report any loss.

Parameters:
- kTicksPerBit, 25000, clock cycles per bit at 30 MHz / 1200 baud.
- kTicksPerBitOverclock, 20000, clock cycles per bit when overclock=1 (10 bits per frame gives 200000 cycles per byte).
- kFifoDepth, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, 30 MHz.
- reset  in  1  asynchronous, active-high reset.
- serial_in  bytestream.sink  -  byte input; members data[7:0] and write (1-cycle strobe); no ready signal.
- overclock  in  1  selects kTicksPerBitOverclock.
- flush  in  1  discards queued bytes (driven from RTS assertion).
- txd  out  1  serial line output; idle high.
- busy  out  1  high when the FIFO is non-empty or a frame is in progress.
- overflow  out  1  sticky flag: a byte was dropped on a full FIFO.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - txd=1, busy=0, overflow=0.
  - FIFO empty, FSM in IDLE, bit counter 0.
  - No partial frame resumes after reset is released.
- FIFO write:
  - serial_in.write=1 with count<kFifoDepth stores data at the write pointer.
  - serial_in.write=1 with count==kFifoDepth drops the byte and sets overflow=1; overflow holds until reset.
  - Write and pop in the same cycle are both performed, including when the FIFO is full, so no drop occurs in that case.
  - Pointers wrap modulo kFifoDepth; count width is clog2(kFifoDepth)+1.
- flush=1:
  - Empties the FIFO in that cycle; a write in the same cycle is discarded, and this does not set overflow.
  - The frame currently on txd completes unaltered.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If count!=0 at a clock edge, pop the head into the shift register and latch overclock for the whole frame. Go to START with txd=0 and the bit timer loaded with T-1, where T is the latched tick count. First start-bit cycle is the edge after the byte is visible in the FIFO.
  - START: hold txd=0 for T cycles. Then go to DATA with bit index 0.
  - DATA: txd = shift[index], LSB first, T cycles per bit, index 0..7. After index 7 expires go to STOP.
  - STOP: txd=1 for T cycles. On expiry, if FIFO non-empty, pop and enter START directly with no idle cycle. Otherwise go to IDLE.
- Frame length is exactly 10*T cycles.
- A change of overclock mid-frame affects only the next frame.
- busy = (state!=IDLE) || (count!=0). It is registered consistently with state, so it is high from the cycle after the first write until the last stop bit expires.
- No parity; the data byte is transmitted verbatim, including bit 7.

Test Plan:
- Single byte: write 0xCD while idle, overclock=0 -> txd 0, then 1,0,1,1,0,0,1,1, then 1, each level held 25000 cycles; total 250000 cycles; busy falls after the stop bit; overflow=0.
- Overclock: same byte with overclock=1 -> each bit 20000 cycles, frame 200000. Toggling overclock at cycle 50000 of a frame leaves that frame at 20000 cycles per bit.
- Back-to-back: write 0xC0, 0x80, 0x85 on consecutive cycles -> three frames with start bits exactly 250000 cycles apart; no extra high cycle between frames.
- Overflow: 6 consecutive writes 0x01..0x06 while idle -> 0x01 popped at the second edge; 0x02-0x05 queued; 0x06 dropped; overflow=1 sticky. Transmitted sequence is 0x01..0x05.
- Flush: queue 3 bytes, pulse flush during the first byte's DATA phase -> the first byte completes correctly, nothing further is sent, busy drops after its stop bit.
- Reset mid-frame: assert reset during bit 3 of a frame -> txd=1 immediately, busy=0. After release, a new write 0x4A transmits a clean full frame.
